// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the control-word pipeline.
// Holds the decoded control-word field positions, a packed view of the word, and the
// default pipeline configuration.
package pipe_ctrl_pkg;

  localparam int unsigned DEF_CTRL_W    = 32;
  localparam int unsigned DEF_NSTAGES   = 3;
  localparam int unsigned DEF_MC_CYCLES = 32;
  localparam int unsigned DEF_MC_BIT    = 0;

  // Control-word field bit positions.
  localparam int unsigned MEMTOREG_BIT   = 0;
  localparam int unsigned MEMWRITE_BIT   = 1;
  localparam int unsigned ALUSRC_BIT     = 2;
  localparam int unsigned REGDST_BIT     = 3;
  localparam int unsigned REGWRITE_BIT   = 4;
  localparam int unsigned ALUCONTROL_LSB = 5;
  localparam int unsigned ALUCONTROL_W   = 5;
  localparam int unsigned SA_LSB         = 10;
  localparam int unsigned SA_W           = 5;
  localparam int unsigned HILOWRITE_BIT  = 15;
  localparam int unsigned JALR_BIT       = 16;
  localparam int unsigned JBRAL_BIT      = 17;

  // Default keep mask for the default configuration: every stage keeps every bit.
  localparam logic [DEF_NSTAGES*DEF_CTRL_W-1:0] DEF_KEEP_MASK = '1;

  // Packed view of the default-width control word.
  typedef struct packed {
    logic [13:0]             rsvd;
    logic                    jbral;
    logic                    jalr;
    logic                    hilowrite;
    logic [SA_W-1:0]         sa;
    logic [ALUCONTROL_W-1:0] alucontrol;
    logic                    regwrite;
    logic                    regdst;
    logic                    alusrc;
    logic                    memwrite;
    logic                    memtoreg;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Bus bundle for ctrl_pipe_chain.
// master: decode-side driver (control word, valid, per-stage stall/flush) and observer
//         of the staged words, decode stall and multi-cycle counter.
// slave : the pipeline itself.
interface ctrl_pipe_chain_if #(
  parameter int unsigned CTRL_W  = 32,
  parameter int unsigned NSTAGES = 3,
  parameter int unsigned CNT_W   = 6
);
  logic [CTRL_W-1:0]         ctrl_d;
  logic                      valid_d;
  logic [NSTAGES-1:0]        stall_i;
  logic [NSTAGES-1:0]        flush_i;
  logic [NSTAGES*CTRL_W-1:0] ctrl_o;
  logic [NSTAGES-1:0]        valid_o;
  logic                      stall_d_o;
  logic                      mc_busy_o;
  logic [CNT_W-1:0]          mc_cnt_o;

  modport master (
    output ctrl_d, valid_d, stall_i, flush_i,
    input  ctrl_o, valid_o, stall_d_o, mc_busy_o, mc_cnt_o
  );

  modport slave (
    input  ctrl_d, valid_d, stall_i, flush_i,
    output ctrl_o, valid_o, stall_d_o, mc_busy_o, mc_cnt_o
  );
endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register for a control word plus its valid bit.
// Update priority: flush (clear) > hold (keep) > bubble (clear) > load (masked source).
// Ports: clk, rst_n (async active-low), flush_i, hold_i, bubble_i, ctrl_i/valid_i (source),
//        ctrl_o/valid_o (registered stage contents).
module ctrl_stage_reg #(
  parameter int unsigned        CTRL_W = 32,
  parameter logic [CTRL_W-1:0]  KEEP   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;

  // Next-state selection.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (flush_i) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (hold_i) begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
    end else if (bubble_i) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = ctrl_i & KEEP;
      valid_d = valid_i;
    end
  end

  // Stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from decode through NSTAGES stage registers (0 = E, 1 = M, 2 = W...).
// Per-stage valid, stall/flush with bubble insertion, per-stage keep masking, and a
// multi-cycle counter that holds stage 0 while a long op (e.g. HI/LO divide) runs.
// Ports: clk, rst (async active-low), bus (slave modport): ctrl_d/valid_d in,
//        stall_i/flush_i per stage in, ctrl_o/valid_o per stage out, stall_d_o (comb),
//        mc_busy_o, mc_cnt_o.
module ctrl_pipe_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned                   CTRL_W    = DEF_CTRL_W,
  parameter int unsigned                   NSTAGES   = DEF_NSTAGES,
  parameter logic [NSTAGES*CTRL_W-1:0]     KEEP_MASK = '1,
  parameter int unsigned                   MC_BIT    = DEF_MC_BIT,
  parameter int unsigned                   MC_CYCLES = DEF_MC_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_pipe_chain_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MC_CYCLES + 1);

  logic [NSTAGES-1:0] eff_stall;
  logic [NSTAGES-1:0] hold_c;
  logic [NSTAGES-1:0] bubble_c;
  logic [CTRL_W-1:0]  src_ctrl   [NSTAGES];
  logic               src_valid  [NSTAGES];
  logic [CTRL_W-1:0]  stage_ctrl [NSTAGES];
  logic               stage_valid[NSTAGES];

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mc_busy_q, mc_busy_d;
  logic               load0_c;

  // Hold chain: a stall freezes its own stage and every earlier stage.
  always_comb begin
    eff_stall    = bus.stall_i;
    eff_stall[0] = bus.stall_i[0] | mc_busy_q;
    hold_c       = '0;
    hold_c[NSTAGES-1] = eff_stall[NSTAGES-1];
    for (int k = int'(NSTAGES) - 2; k >= 0; k--) begin
      hold_c[k] = eff_stall[k] | hold_c[k+1];
    end
  end

  // A stage whose predecessor is held (and which itself moves) takes a bubble.
  always_comb begin
    bubble_c    = '0;
    for (int k = 1; k < int'(NSTAGES); k++) begin
      bubble_c[k] = hold_c[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    if (k == 0) begin : g_src_dec
      assign src_ctrl[k]  = bus.ctrl_d;
      assign src_valid[k] = bus.valid_d;
    end else begin : g_src_prev
      assign src_ctrl[k]  = stage_ctrl[k-1];
      assign src_valid[k] = stage_valid[k-1];
    end

    ctrl_stage_reg #(
      .CTRL_W (CTRL_W),
      .KEEP   (KEEP_MASK[k*CTRL_W +: CTRL_W])
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst),
      .flush_i  (bus.flush_i[k]),
      .hold_i   (hold_c[k]),
      .bubble_i (bubble_c[k]),
      .ctrl_i   (src_ctrl[k]),
      .valid_i  (src_valid[k]),
      .ctrl_o   (stage_ctrl[k]),
      .valid_o  (stage_valid[k])
    );

    assign bus.ctrl_o[k*CTRL_W +: CTRL_W] = stage_ctrl[k];
    assign bus.valid_o[k]                 = stage_valid[k];
  end

  // Stage 0 takes a new word only when neither flushed nor held.
  assign load0_c = !bus.flush_i[0] && !hold_c[0];

  // Multi-cycle counter: started by a valid MC op entering stage 0, killed by a stage-0 flush.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.flush_i[0]) begin
      cnt_d = '0;
    end else if (load0_c && bus.valid_d && bus.ctrl_d[MC_BIT]) begin
      cnt_d = CNT_W'(MC_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    mc_busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      mc_busy_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mc_busy_q <= mc_busy_d;
    end
  end

  assign bus.stall_d_o = hold_c[0];
  assign bus.mc_busy_o = mc_busy_q;
  assign bus.mc_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain: NSTAGES=3, MC_CYCLES=4, MC bit = hilowrite,
// W slice keep mask 0x0000_000F. Each directed row drives one cycle of inputs and
// queues the outputs expected to be visible during that cycle; a monitor pops and compares.
module tb_ctrl_pipe_chain;
  import pipe_ctrl_pkg::*;

  localparam int unsigned CW   = 32;
  localparam int unsigned NS   = 3;
  localparam int unsigned MCC  = 4;
  localparam int unsigned CNTW = $clog2(MCC + 1);
  localparam logic [NS*CW-1:0] KEEP = {32'h0000_000F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  typedef struct {
    logic        rst;
    logic [31:0] ctrl;
    logic        vld;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic [31:0] e, m, w;
    logic [2:0]  vo;
    logic        sd;
    logic [31:0] cnt;
  } row_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  bit   done;
  row_t vec[$];
  row_t sb[$];

  ctrl_pipe_chain_if #(.CTRL_W(CW), .NSTAGES(NS), .CNT_W(CNTW)) bif ();

  ctrl_pipe_chain #(
    .CTRL_W    (CW),
    .NSTAGES   (NS),
    .KEEP_MASK (KEEP),
    .MC_BIT    (HILOWRITE_BIT),
    .MC_CYCLES (MCC)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [31:0] c, input logic v, input logic [2:0] st,
                     input logic [2:0] fl, input logic [31:0] e, input logic [31:0] m,
                     input logic [31:0] w, input logic [2:0] vo, input logic sd,
                     input logic [31:0] cnt);
    row_t x;
    x.rst = r; x.ctrl = c; x.vld = v; x.stall = st; x.flush = fl;
    x.e = e; x.m = m; x.w = w; x.vo = vo; x.sd = sd; x.cnt = cnt;
    vec.push_back(x);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Monitor: compares visible outputs once per cycle, after the driver has applied inputs.
  initial begin
    int r;
    r = 0;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        row_t x;
        x = sb.pop_front();
        chk("ctrl_E",  r, bif.ctrl_o[31:0],  x.e);
        chk("ctrl_M",  r, bif.ctrl_o[63:32], x.m);
        chk("ctrl_W",  r, bif.ctrl_o[95:64], x.w);
        chk("valid",   r, 32'(bif.valid_o),  32'(x.vo));
        chk("stall_d", r, 32'(bif.stall_d_o), 32'(x.sd));
        chk("mc_cnt",  r, 32'(bif.mc_cnt_o), x.cnt);
        chk("mc_busy", r, 32'(bif.mc_busy_o), 32'(x.cnt != 0));
        r++;
      end
    end
  end

  // Driver.
  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b0;
    bif.ctrl_d = '0; bif.valid_d = 1'b0; bif.stall_i = '0; bif.flush_i = '0;

    //    rst ctrl          v  stall   flush   E             M             W      V       sd cnt
    add(0, 32'h0,        0, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 3'b000, 0, 0); // 0 reset
    add(1, 32'hA5,       1, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 3'b000, 0, 0); // 1
    add(1, 32'h0,        0, 3'b000, 3'b000, 32'hA5,       32'h0,        32'h0, 3'b001, 0, 0); // 2
    add(1, 32'h0,        0, 3'b000, 3'b000, 32'h0,        32'hA5,       32'h0, 3'b010, 0, 0); // 3
    add(1, 32'hFF,       1, 3'b000, 3'b000, 32'h0,        32'h0,        32'h5, 3'b100, 0, 0); // 4 masked W
    add(1, 32'h0,        0, 3'b000, 3'b000, 32'hFF,       32'h0,        32'h0, 3'b001, 0, 0); // 5
    add(1, 32'h11,       1, 3'b000, 3'b000, 32'h0,        32'hFF,       32'h0, 3'b010, 0, 0); // 6
    add(1, 32'h22,       1, 3'b000, 3'b000, 32'h11,       32'h0,        32'hF, 3'b101, 0, 0); // 7
    add(1, 32'h33,       1, 3'b000, 3'b000, 32'h22,       32'h11,       32'h0, 3'b011, 0, 0); // 8
    add(1, 32'h44,       1, 3'b010, 3'b000, 32'h33,       32'h22,       32'h1, 3'b111, 1, 0); // 9 stall M
    add(1, 32'h44,       1, 3'b000, 3'b000, 32'h33,       32'h22,       32'h0, 3'b011, 0, 0); // 10 W bubble
    add(1, 32'h55,       1, 3'b001, 3'b001, 32'h44,       32'h33,       32'h2, 3'b111, 1, 0); // 11 flush+stall E
    add(1, 32'h55,       1, 3'b000, 3'b000, 32'h0,        32'h0,        32'h3, 3'b100, 0, 0); // 12
    add(1, 32'h8001,     1, 3'b000, 3'b000, 32'h55,       32'h0,        32'h0, 3'b001, 0, 0); // 13 MC op
    add(1, 32'h66,       1, 3'b000, 3'b000, 32'h8001,     32'h55,       32'h0, 3'b011, 1, 3); // 14
    add(1, 32'h66,       1, 3'b000, 3'b000, 32'h8001,     32'h0,        32'h5, 3'b101, 1, 2); // 15
    add(1, 32'h66,       1, 3'b000, 3'b000, 32'h8001,     32'h0,        32'h0, 3'b001, 1, 1); // 16
    add(1, 32'h66,       1, 3'b000, 3'b000, 32'h8001,     32'h0,        32'h0, 3'b001, 0, 0); // 17
    add(1, 32'h8001,     0, 3'b000, 3'b000, 32'h66,       32'h8001,     32'h0, 3'b011, 0, 0); // 18 MC bit, invalid
    add(1, 32'h8002,     1, 3'b000, 3'b000, 32'h8001,     32'h66,       32'h1, 3'b110, 0, 0); // 19
    add(1, 32'h0,        0, 3'b000, 3'b000, 32'h8002,     32'h8001,     32'h6, 3'b101, 1, 3); // 20
    add(0, 32'h0,        0, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 3'b000, 0, 0); // 21 async reset, cnt was 2
    add(0, 32'h0,        0, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 3'b000, 0, 0); // 22
    add(1, 32'h0,        0, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 3'b000, 0, 0); // 23
    add(1, 32'h8004,     1, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 3'b000, 0, 0); // 24
    add(1, 32'h77,       1, 3'b000, 3'b001, 32'h8004,     32'h0,        32'h0, 3'b001, 1, 3); // 25 flush E while busy
    add(1, 32'h77,       1, 3'b000, 3'b000, 32'h0,        32'h0,        32'h0, 3'b000, 0, 0); // 26
    add(1, 32'h88,       1, 3'b100, 3'b000, 32'h77,       32'h0,        32'h0, 3'b001, 1, 0); // 27 stall W
    add(1, 32'h88,       1, 3'b000, 3'b000, 32'h77,       32'h0,        32'h0, 3'b001, 0, 0); // 28
    add(1, 32'h0,        0, 3'b010, 3'b010, 32'h88,       32'h77,       32'h0, 3'b011, 1, 0); // 29 flush+stall M
    add(1, 32'h0,        0, 3'b000, 3'b000, 32'h88,       32'h0,        32'h0, 3'b001, 0, 0); // 30
    add(1, 32'h0,        0, 3'b000, 3'b000, 32'h0,        32'h88,       32'h0, 3'b010, 0, 0); // 31

    foreach (vec[i]) begin
      @(negedge clk);
      #1;
      rst         = vec[i].rst;
      bif.ctrl_d  = vec[i].ctrl;
      bif.valid_d = vec[i].vld;
      bif.stall_i = vec[i].stall;
      bif.flush_i = vec[i].flush;
      sb.push_back(vec[i]);
    end

    @(negedge clk);
    #5;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
